// File: rtl/alu_ctrl_pkg.sv
// Shared types and opcode helpers for the ALU controller.
// Compact opcodes 0..8 map onto the ALU's one-hot op code bus; 9..15 are rejected.
package alu_ctrl_pkg;

  localparam int NUM_OPS = 9;

  typedef enum logic [3:0] {
    OP_SUM  = 4'd0,
    OP_DIFF = 4'd1,
    OP_NOT  = 4'd2,
    OP_NAND = 4'd3,
    OP_NOR  = 4'd4,
    OP_AND  = 4'd5,
    OP_XOR  = 4'd6,
    OP_OR   = 4'd7,
    OP_XNOR = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (int'(op) < NUM_OPS);
  endfunction

  function automatic logic [15:0] op_to_onehot(input logic [3:0] op);
    return op_is_legal(op) ? (16'h0001 << op) : 16'h0000;
  endfunction

endpackage

// File: rtl/alu_ctrl_arbiter.sv
// Two-way request arbiter for the ALU controller.
// ALU_CTRL_RR_ARB_EN selects round-robin; otherwise requester 0 has fixed priority.
module alu_ctrl_arbiter
  import alu_ctrl_pkg::*;
(
`ifdef ALU_CTRL_RR_ARB_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
`endif
  input  logic [1:0] req_valid,
  output logic [1:0] grant,
  output logic       grant_id
);

`ifdef ALU_CTRL_RR_ARB_EN
  logic ptr;

  // Pointer names the preferred requester and flips away from whoever was just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_id;
    end
  end

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req_valid[0]) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant = 2'b10;
    end
  end
`endif

  assign grant_id = grant[1];

endmodule

// File: rtl/alu_controller.sv
// Sequences the shared 8-bit ALU for two requesters: arbitrate, issue, capture, respond.
// Arbitration mode is chosen by ALU_CTRL_RR_ARB_EN inside alu_ctrl_arbiter.
module alu_controller
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [7:0]         req_op,
  input  logic [15:0]        req_a,
  input  logic [15:0]        req_b,
  output logic [15:0]        alu_op_code,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_result,
  input  logic               alu_carry,
  input  logic               alu_neg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [7:0]         rsp_result,
  output logic               rsp_carry,
  output logic               rsp_neg,
  output logic               rsp_err,
  output logic               busy
);

  state_t     state;
  logic [1:0] grant;
  logic       grant_id;
  logic       accept;
  logic [3:0] sel_op;
  logic [7:0] sel_a;
  logic [7:0] sel_b;

  alu_ctrl_arbiter u_arbiter (
`ifdef ALU_CTRL_RR_ARB_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
`endif
    .req_valid (req_valid),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign busy      = (state != IDLE);

  assign sel_op = grant_id ? req_op[7:4] : req_op[3:0];
  assign sel_a  = grant_id ? req_a[15:8] : req_a[7:0];
  assign sel_b  = grant_id ? req_b[15:8] : req_b[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_op_code <= 16'h0000;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= 8'h00;
      rsp_carry   <= 1'b0;
      rsp_neg     <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= grant_id;
            if (op_is_legal(sel_op)) begin
              alu_op_code <= op_to_onehot(sel_op);
              alu_a       <= sel_a;
              alu_b       <= sel_b;
              state       <= ISSUE;
            end else begin
              // Illegal opcodes never reach the ALU; answer straight away.
              rsp_result <= 8'h00;
              rsp_carry  <= 1'b0;
              rsp_neg    <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          alu_op_code <= 16'h0000;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_neg    <= alu_neg;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_controller.sv
// Directed self-checking bench for alu_controller with a registered ALU model attached.
// Arbitration expectations follow ALU_CTRL_RR_ARB_EN.
module tb_alu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [15:0] alu_op_code;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_neg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_carry;
  logic        rsp_neg;
  logic        rsp_err;
  logic        busy;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_controller #(.NUM_REQ(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_op_code (alu_op_code),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_neg     (alu_neg),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_carry   (rsp_carry),
    .rsp_neg     (rsp_neg),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  // Registered ALU: result and flags appear one edge after the op code is presented.
  always @(posedge clk) begin
    logic [8:0] t;
    t = 9'h000;
    case (alu_op_code)
      16'h0001: t = {1'b0, alu_a} + {1'b0, alu_b};
      16'h0002: t = {1'b0, alu_a} - {1'b0, alu_b};
      16'h0004: t = {1'b0, ~alu_a};
      16'h0008: t = {1'b0, ~(alu_a & alu_b)};
      16'h0010: t = {1'b0, ~(alu_a | alu_b)};
      16'h0020: t = {1'b0, alu_a & alu_b};
      16'h0040: t = {1'b0, alu_a ^ alu_b};
      16'h0080: t = {1'b0, alu_a | alu_b};
      16'h0100: t = {1'b0, ~(alu_a ^ alu_b)};
      default:  t = 9'h000;
    endcase
    alu_result <= t[7:0];
    alu_carry  <= t[8];
    alu_neg    <= t[7];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] valid, input logic [7:0] op,
                                input logic [15:0] a, input logic [15:0] b);
    req_valid = valid;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [3:0] exp_ids;
  logic       gid;

  initial begin
`ifdef ALU_CTRL_RR_ARB_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    alu_neg    = 1'b0;
    apply_stimulus(2'b11, 8'h00, 16'h0000, 16'h0000);
    tick;
    tick;
    check_output("reset_req_ready", 16'(req_ready), 16'h0000);
    check_output("reset_op_code", alu_op_code, 16'h0000);
    check_output("reset_rsp_valid", 16'(rsp_valid), 16'h0000);
    check_output("reset_busy", 16'(busy), 16'h0000);
    check_output("reset_rsp_result", 16'(rsp_result), 16'h0000);
    rst_n = 1'b1;
    apply_stimulus(2'b00, 8'h00, 16'h0000, 16'h0000);
    tick;

    // Requester 0 SUM 12+34
    apply_stimulus(2'b01, 8'h00, 16'h0012, 16'h0034);
    check_output("sum_req_ready", 16'(req_ready), 16'h0001);
    check_output("sum_idle_op_code", alu_op_code, 16'h0000);
    tick;
    req_valid = 2'b00;
    check_output("sum_op_code", alu_op_code, 16'h0001);
    check_output("sum_alu_a", 16'(alu_a), 16'h0012);
    check_output("sum_alu_b", 16'(alu_b), 16'h0034);
    check_output("sum_busy", 16'(busy), 16'h0001);
    check_output("sum_early_valid", 16'(rsp_valid), 16'h0000);
    tick;
    check_output("sum_capture_op_code", alu_op_code, 16'h0000);
    check_output("sum_capture_valid", 16'(rsp_valid), 16'h0000);
    tick;
    check_output("sum_rsp_valid", 16'(rsp_valid), 16'h0001);
    check_output("sum_rsp_result", 16'(rsp_result), 16'h0046);
    check_output("sum_rsp_id", 16'(rsp_id), 16'h0000);
    check_output("sum_rsp_err", 16'(rsp_err), 16'h0000);
    check_output("sum_rsp_carry", 16'(rsp_carry), 16'h0000);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check_output("sum_done_valid", 16'(rsp_valid), 16'h0000);
    check_output("sum_done_busy", 16'(busy), 16'h0000);

    // Requester 1 DIFF 05-09, then response held off for 5 cycles
    apply_stimulus(2'b10, 8'h10, 16'h0500, 16'h0900);
    check_output("diff_req_ready", 16'(req_ready), 16'h0002);
    tick;
    check_output("diff_op_code", alu_op_code, 16'h0002);
    check_output("diff_alu_a", 16'(alu_a), 16'h0005);
    req_valid = 2'b11;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      check_output("diff_hold_valid", 16'(rsp_valid), 16'h0001);
      check_output("diff_hold_result", 16'(rsp_result), 16'h00FC);
      check_output("diff_hold_neg", 16'(rsp_neg), 16'h0001);
      check_output("diff_hold_carry", 16'(rsp_carry), 16'h0001);
      check_output("diff_hold_id", 16'(rsp_id), 16'h0001);
      check_output("diff_hold_req_ready", 16'(req_ready), 16'h0000);
      check_output("diff_hold_busy", 16'(busy), 16'h0001);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check_output("diff_release_valid", 16'(rsp_valid), 16'h0000);
    check_output("diff_release_busy", 16'(busy), 16'h0000);

    // Illegal opcode C from requester 0
    apply_stimulus(2'b01, 8'h0C, 16'h00AA, 16'h0055);
    check_output("ill_req_ready", 16'(req_ready), 16'h0001);
    tick;
    req_valid = 2'b00;
    check_output("ill_rsp_valid", 16'(rsp_valid), 16'h0001);
    check_output("ill_rsp_err", 16'(rsp_err), 16'h0001);
    check_output("ill_rsp_result", 16'(rsp_result), 16'h0000);
    check_output("ill_rsp_carry", 16'(rsp_carry), 16'h0000);
    check_output("ill_rsp_neg", 16'(rsp_neg), 16'h0000);
    check_output("ill_op_code", alu_op_code, 16'h0000);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check_output("ill_done_valid", 16'(rsp_valid), 16'h0000);
    check_output("ill_done_op_code", alu_op_code, 16'h0000);

    // Reset pulsed during CAPTURE drops the in-flight request
    apply_stimulus(2'b01, 8'h00, 16'h00FF, 16'h0001);
    tick;
    req_valid = 2'b00;
    check_output("rst_issue_op_code", alu_op_code, 16'h0001);
    tick;
    #2;
    rst_n = 1'b0;
    req_valid = 2'b01;
    #1;
    check_output("rst_async_busy", 16'(busy), 16'h0000);
    check_output("rst_async_alu_a", 16'(alu_a), 16'h0000);
    check_output("rst_async_alu_b", 16'(alu_b), 16'h0000);
    check_output("rst_async_req_ready", 16'(req_ready), 16'h0000);
    check_output("rst_async_valid", 16'(rsp_valid), 16'h0000);
    tick;
    check_output("rst_hold_valid", 16'(rsp_valid), 16'h0000);
    rst_n = 1'b1;
    req_valid = 2'b00;
    tick;
    tick;
    tick;
    check_output("rst_after_valid", 16'(rsp_valid), 16'h0000);
    check_output("rst_after_busy", 16'(busy), 16'h0000);

    // Fresh request after reset: requester 1 XOR AA^0F
    apply_stimulus(2'b10, 8'h60, 16'hAA00, 16'h0F00);
    check_output("fresh_req_ready", 16'(req_ready), 16'h0002);
    tick;
    req_valid = 2'b00;
    check_output("fresh_op_code", alu_op_code, 16'h0040);
    tick;
    tick;
    check_output("fresh_rsp_valid", 16'(rsp_valid), 16'h0001);
    check_output("fresh_rsp_result", 16'(rsp_result), 16'h00A5);
    check_output("fresh_rsp_neg", 16'(rsp_neg), 16'h0001);
    check_output("fresh_rsp_id", 16'(rsp_id), 16'h0001);
    rsp_ready = 1'b1;
    tick;

    // Both requesters continuously valid, responses drained immediately
    apply_stimulus(2'b11, 8'h75, 16'h0FF0, 16'hF03C);
    for (int i = 0; i < 4; i++) begin
      gid = exp_ids[i];
      check_output("arb_req_ready", 16'(req_ready), gid ? 16'h0002 : 16'h0001);
      check_output("arb_idle_busy", 16'(busy), 16'h0000);
      tick;
      check_output("arb_op_code", alu_op_code, gid ? 16'h0080 : 16'h0020);
      tick;
      tick;
      check_output("arb_rsp_valid", 16'(rsp_valid), 16'h0001);
      check_output("arb_rsp_id", 16'(rsp_id), 16'(gid));
      check_output("arb_rsp_result", 16'(rsp_result), gid ? 16'h00FF : 16'h0030);
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    tick;
    check_output("end_busy", 16'(busy), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
